inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/riscv_inst_pkg.sv | 47 ++++
 rtl/sync_fifo.sv | 47 ++++
 rtl/inst_encoder.sv | 157 +++++++++++++++
 tb/tb_inst_encoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_inst_pkg.sv
// Shared RV32I encoding constants: request op-classes, major opcodes,
// funct3/funct7 values and immediate range helpers. Imported by the
// instruction encoder and by control_logic so both agree on encodings.
package riscv_inst_pkg;

  // Request op-class as presented on req_op; codes 9-15 are illegal.
  typedef enum logic [3:0] {
    OP_R      = 4'd0,
    OP_IMM    = 4'd1,
    OP_LOAD   = 4'd2,
    OP_STORE  = 4'd3,
    OP_BRANCH = 4'd4,
    OP_LUI    = 4'd5,
    OP_AUIPC  = 4'd6,
    OP_JAL    = 4'd7,
    OP_JALR   = 4'd8
  } op_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_JALR    = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // True when v is a sign-extended value of 'bits' width, i.e. all bits
  // from bits-1 upward are copies of the sign bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] upper;
    logic [31:0] mask;
    mask  = 32'hFFFF_FFFF << (bits - 1);
    upper = v & mask;
    return (upper == 32'd0) || (upper == mask);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and no same-cycle bypass.
// Ports: clk/rst (async active-high), push/wdata, pop/rdata (head word,
// valid while !empty), full, empty. Pushes while full and pops while
// empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 46,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is only observed while !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder. Accepts encode requests, packs them into
// 32-bit instruction words, tags each with a word address from a
// loadable counter and queues {inst, addr} in a FIFO.
// Ports: clk, rst (async active-high); req_* request handshake and
// fields; base_load/base_addr counter load; out_valid/out_ready/out_inst/
// out_addr output stream; err sticky range error with err_clear; count
// saturating number of words dequeued.
module inst_encoder
  import riscv_inst_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [2:0]        req_funct3,
  input  logic              req_alt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  input  logic              err_clear,
  output logic [15:0]       count
);

  localparam int FW = 32 + ADDR_W;

  logic              fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_rdata;
  logic              accept, push, pop;
  logic [31:0]       inst;
  logic              range_err;
  logic [ADDR_W-1:0] addr_ctr, tag_addr;
  logic [6:0]        f7;
  logic [31:0]       imm;

  assign imm = req_imm;

  // ---------------- encoding ----------------
  always_comb begin
    inst      = '0;
    range_err = 1'b0;
    f7        = F7_BASE;
    case (op_e'(req_op))
      OP_R: begin
        if (req_alt && (req_funct3 == F3_ADD_SUB || req_funct3 == F3_SRL_SRA)) f7 = F7_ALT;
        inst = {f7, req_rs2, req_rs1, req_funct3, req_rd, OPC_R};
      end
      OP_IMM: begin
        if (req_funct3 == F3_SLL || req_funct3 == F3_SRL_SRA) begin
          // Shifts carry a 5-bit shamt in the rs2 slot and funct7 above it.
          range_err = |imm[31:5];
          if (req_alt && req_funct3 == F3_SRL_SRA) f7 = F7_ALT;
          inst = {f7, imm[4:0], req_rs1, req_funct3, req_rd, OPC_IMM};
        end else begin
          range_err = !fits_signed(imm, 12);
          inst = {imm[11:0], req_rs1, req_funct3, req_rd, OPC_IMM};
        end
      end
      OP_LOAD: begin
        range_err = !fits_signed(imm, 12);
        inst = {imm[11:0], req_rs1, req_funct3, req_rd, OPC_LOAD};
      end
      OP_STORE: begin
        range_err = !fits_signed(imm, 12);
        inst = {imm[11:5], req_rs2, req_rs1, req_funct3, imm[4:0], OPC_STORE};
      end
      OP_BRANCH: begin
        range_err = !fits_signed(imm, 13) || imm[0];
        inst = {imm[12], imm[10:5], req_rs2, req_rs1, req_funct3, imm[4:1], imm[11], OPC_BRANCH};
      end
      OP_LUI: begin
        range_err = |imm[11:0];
        inst = {imm[31:12], req_rd, OPC_LUI};
      end
      OP_AUIPC: begin
        range_err = |imm[11:0];
        inst = {imm[31:12], req_rd, OPC_AUIPC};
      end
      OP_JAL: begin
        range_err = !fits_signed(imm, 21) || imm[0];
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], req_rd, OPC_JAL};
      end
      OP_JALR: begin
        range_err = !fits_signed(imm, 12);
        inst = {imm[11:0], req_rs1, F3_JALR, req_rd, OPC_JALR};
      end
      default: range_err = 1'b1;
    endcase
  end

  // ---------------- handshake ----------------
  // No pop bypass: a full FIFO refuses requests even while it drains.
  assign req_ready = !fifo_full && !rst;
  assign accept    = req_valid && req_ready;
  assign push      = accept && !range_err;
  assign pop       = out_valid && out_ready;

  // A same-cycle base load tags the word being enqueued.
  assign tag_addr = base_load ? base_addr : addr_ctr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_ctr <= '0;
    end else if (base_load || push) begin
      addr_ctr <= tag_addr + {{(ADDR_W-1){1'b0}}, push};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && range_err) begin
      err <= 1'b1;
    end else if (err_clear) begin
      err <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (pop && count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({inst, tag_addr}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  // Zero the outputs when nothing is queued so stale storage never leaks.
  assign out_inst  = out_valid ? fifo_rdata[FW-1:ADDR_W] : 32'd0;
  assign out_addr  = out_valid ? fifo_rdata[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_alt;
  logic [3:0]        req_op;
  logic [2:0]        req_funct3;
  logic [4:0]        req_rd, req_rs1, req_rs2;
  logic [31:0]       req_imm;
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              out_valid, out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              err, err_clear;
  logic [15:0]       count;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_funct3(req_funct3), .req_alt(req_alt),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .base_load(base_load), .base_addr(base_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .err(err), .err_clear(err_clear), .count(count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: queue of {inst, addr}, counter, err, pop count.
  typedef logic [32+ADDR_W-1:0] ent_t;
  ent_t              mq[$];
  logic [ADDR_W-1:0] m_ctr;
  logic              m_err;
  int                m_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Encoding model built from field positions and numeric ranges.
  function automatic void model_enc(input int op, input int f3, input bit alt,
                                    input int rd, input int rs1, input int rs2,
                                    input logic [31:0] u, output logic [31:0] inst,
                                    output bit bad);
    int opc_tab[9] = '{51, 19, 3, 35, 99, 55, 23, 111, 103};
    longint s;
    logic [31:0] opc, f7;
    s = longint'($signed(u));
    inst = 0; bad = 0;
    if (op > 8) begin bad = 1; return; end
    opc = opc_tab[op];
    case (op)
      0: begin
        f7 = (alt && (f3 == 0 || f3 == 5)) ? 32 : 0;
        inst = f7 << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | rd << 7 | opc;
      end
      1: if (f3 == 1 || f3 == 5) begin
        bad = (u > 31);
        f7 = (f3 == 5 && alt) ? 32 : 0;
        inst = f7 << 25 | (u & 31) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | opc;
      end else begin
        bad = (s < -2048 || s > 2047);
        inst = (u & 'hFFF) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | opc;
      end
      2, 8: begin
        bad = (s < -2048 || s > 2047);
        inst = (u & 'hFFF) << 20 | rs1 << 15 | (op == 8 ? 0 : f3) << 12 | rd << 7 | opc;
      end
      3: begin
        bad = (s < -2048 || s > 2047);
        inst = ((u >> 5) & 127) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | (u & 31) << 7 | opc;
      end
      4: begin
        bad = (s < -4096 || s > 4095 || u[0]);
        inst = ((u >> 12) & 1) << 31 | ((u >> 5) & 63) << 25 | rs2 << 20 | rs1 << 15 |
               f3 << 12 | ((u >> 1) & 15) << 8 | ((u >> 11) & 1) << 7 | opc;
      end
      5, 6: begin
        bad = ((u & 'hFFF) != 0);
        inst = (u & 32'hFFFF_F000) | rd << 7 | opc;
      end
      default: begin
        bad = (s < -(1 << 20) || s > (1 << 20) - 1 || u[0]);
        inst = ((u >> 20) & 1) << 31 | ((u >> 1) & 1023) << 21 | ((u >> 11) & 1) << 20 |
               ((u >> 12) & 255) << 12 | rd << 7 | opc;
      end
    endcase
  endfunction

  // One clock: compare outputs at the falling edge, then advance the model.
  task automatic tick();
    logic [31:0] mi;
    bit bad, acc, psh, pp;
    @(negedge clk);
    chk("req_ready", req_ready, (mq.size() < DEPTH));
    chk("out_valid", out_valid, (mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_inst", out_inst, mq[0][32+ADDR_W-1:ADDR_W]);
      chk("out_addr", out_addr, mq[0][ADDR_W-1:0]);
    end
    chk("err", err, m_err);
    chk("count", count, m_count);
    model_enc(req_op, req_funct3, req_alt, req_rd, req_rs1, req_rs2, req_imm, mi, bad);
    acc = req_valid && (mq.size() < DEPTH);
    psh = acc && !bad;
    pp  = (mq.size() > 0) && out_ready;
    @(posedge clk); #1;
    if (pp) void'(mq.pop_front());
    if (psh) mq.push_back({mi, base_load ? base_addr : m_ctr});
    if (base_load) m_ctr = base_addr + ADDR_W'(psh);
    else m_ctr = m_ctr + ADDR_W'(psh);
    m_err = (acc && bad) || (m_err && !err_clear);
    if (pp && m_count < 65535) m_count++;
  endtask

  task automatic do_reset();
    rst = 1'b1; #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    mq.delete(); m_ctr = 0; m_err = 0; m_count = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int op, input int f3, input bit alt, input int rd,
                         input int rs1, input int rs2, input logic [31:0] imm);
    req_op = 4'(op); req_funct3 = 3'(f3); req_alt = alt;
    req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2); req_imm = imm;
  endtask

  // Push one request into an empty, draining encoder and check the word.
  task automatic vec(input string tag, input logic [31:0] exp);
    req_valid = 1; tick(); req_valid = 0;
    chk(tag, out_inst, exp);
    tick();
  endtask

  function automatic logic [31:0] rand_imm(input int op);
    if ($urandom_range(0, 7) == 0) return $urandom;
    case (op)
      1: return ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 31)) : 32'($urandom_range(0, 4095) - 2048);
      4: return 32'($urandom_range(0, 4095) - 2048) << 1;
      5, 6: return $urandom & 32'hFFFF_F000;
      7: return 32'($urandom_range(0, 1048575) - 524288) << 1;
      default: return 32'($urandom_range(0, 4095) - 2048);
    endcase
  endfunction

  initial begin
    int op, guard;
    req_valid = 0; out_ready = 1; base_load = 0; base_addr = 0; err_clear = 0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    tick();

    // Known encodings
    set_req(0, 0, 0, 3, 1, 2, 0);                vec("r_add", 32'h002081B3);
    set_req(0, 0, 1, 3, 1, 2, 0);                vec("r_sub", 32'h402081B3);
    set_req(1, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);    vec("addi_m1", 32'hFFF00093);
    set_req(5, 0, 0, 5, 0, 0, 32'h1234_5000);    vec("lui", 32'h123452B7);
    set_req(7, 0, 0, 1, 0, 0, 32'd2048);         vec("jal", 32'h001000EF);
    set_req(4, 0, 0, 0, 1, 2, 32'd8);            vec("beq", 32'h00208463);

    // Range error: nothing enqueued, err sticky until cleared
    set_req(1, 0, 0, 1, 0, 0, 32'd2048);
    req_valid = 1; tick(); req_valid = 0;
    chk("err_no_valid", out_valid, 0);
    chk("err_set", err, 1);
    chk("err_count", count, 6);
    tick();
    err_clear = 1; tick(); err_clear = 0;
    chk("err_cleared", err, 0);
    // clear coinciding with a new error keeps err high
    set_req(9, 0, 0, 0, 0, 0, 0);
    req_valid = 1; err_clear = 1; tick(); req_valid = 0; err_clear = 0;
    chk("err_hold", err, 1);
    err_clear = 1; tick(); err_clear = 0;

    // Backpressure: four fill the FIFO, fifth is held
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 0, 0, i + 1, 1, 2, 0); req_valid = 1; tick();
    end
    chk("full_ready", req_ready, 0);
    set_req(0, 0, 0, 5, 1, 2, 0);
    tick(); tick();
    chk("held_depth", mq.size(), 4);
    out_ready = 1;
    tick(); tick();
    req_valid = 0;
    repeat (6) tick();
    chk("bp_count", count, 5);

    // Address wrap after base load
    base_addr = 14'h3FFF; base_load = 1; tick(); base_load = 0;
    set_req(0, 0, 0, 1, 1, 2, 0); req_valid = 1; tick();
    chk("wrap_a0", out_addr, 14'h3FFF);
    tick(); req_valid = 0;
    chk("wrap_a1", out_addr, 14'h0000);
    tick();
    // Base load coinciding with a push
    base_addr = 14'h0100; base_load = 1; req_valid = 1; tick(); base_load = 0;
    chk("bl_same", out_addr, 14'h0100);
    tick(); req_valid = 0;
    chk("bl_next", out_addr, 14'h0101);
    tick();

    // Reset mid-operation with words queued
    out_ready = 0; req_valid = 1;
    repeat (3) tick();
    req_valid = 0;
    rst = 1; #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_count", count, 0);
    do_reset();
    out_ready = 1;
    req_valid = 1; tick(); req_valid = 0;
    chk("post_rst_addr", out_addr, 0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      op = ($urandom_range(0, 15) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      set_req(op, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), rand_imm(op));
      req_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      base_load = ($urandom_range(0, 15) == 0);
      base_addr = ADDR_W'($urandom);
      err_clear = ($urandom_range(0, 7) == 0);
      tick();
    end
    req_valid = 0; base_load = 0; err_clear = 0; out_ready = 1;
    guard = 0;
    while (mq.size() > 0 && guard < 20) begin tick(); guard++; end
    chk("drain_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
